// File: rtl/sdu_exec_ctrl.sv
// Debug execution controller: gates the CPU clock-enable from RUN/STEP/HALT commands, PC breakpoints, stop cause and retired count.
// Commands take effect the cycle after acceptance; cmd_ready drops only while a single step is executing.
module sdu_exec_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BP     = 2
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [1:0]            cmd_idx,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  cpu_en,
    output logic                  halted,
    output logic [1:0]            stop_cause,
    output logic [1:0]            bp_hit_idx,
    output logic [31:0]           instr_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_STEP   = 3'd2;
    localparam logic [2:0] OP_HALT   = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4;
    localparam logic [2:0] OP_CLR_BP = 3'd5;

    localparam logic [1:0] CAUSE_HALT = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    state_t                state_q, state_d;
    logic                  skip_q, skip_d;
    logic [1:0]            stop_cause_q, stop_cause_d;
    logic [1:0]            bp_hit_idx_q, bp_hit_idx_d;
    logic [31:0]           instr_cnt_q, instr_cnt_d;
    logic [NUM_BP-1:0]     bp_en_q, bp_en_d;
    logic [ADDR_WIDTH-1:0] bp_addr_q [NUM_BP];
    logic [ADDR_WIDTH-1:0] bp_addr_d [NUM_BP];

    logic       cmd_acc;
    logic       bp_match;
    logic [1:0] bp_idx;
    logic       bp_stop;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        bp_match = 1'b0;
        bp_idx   = 2'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (pc == bp_addr_q[i])) begin
                bp_match = 1'b1;
                bp_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        cmd_ready    = (state_q != ST_STEP);
        halted       = (state_q == ST_HALT);
        cmd_acc      = cmd_valid && cmd_ready;
        bp_stop      = 1'b0;
        cpu_en       = 1'b0;
        state_d      = state_q;
        skip_d       = skip_q;
        stop_cause_d = stop_cause_q;
        bp_hit_idx_d = bp_hit_idx_q;

        case (state_q)
            ST_HALT: begin
                if (cmd_acc && (cmd_op == OP_RUN)) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (cmd_acc && (cmd_op == OP_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                // Breakpoint outranks a coincident HALT command and suppresses execution.
                bp_stop = bp_match && !skip_q;
                cpu_en  = !bp_stop;
                if (bp_stop) begin
                    state_d      = ST_HALT;
                    stop_cause_d = CAUSE_BP;
                    bp_hit_idx_d = bp_idx;
                end else if (cmd_acc && (cmd_op == OP_HALT)) begin
                    state_d      = ST_HALT;
                    stop_cause_d = CAUSE_HALT;
                end
            end
            ST_STEP: begin
                cpu_en       = 1'b1;
                state_d      = ST_HALT;
                stop_cause_d = CAUSE_STEP;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (cpu_en) begin
            skip_d = 1'b0;
        end
        instr_cnt_d = instr_cnt_q + {31'd0, cpu_en};
    end

    always_comb begin
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        for (int i = 0; i < NUM_BP; i++) begin
            if (cmd_acc && (cmd_idx == 2'(i))) begin
                if (cmd_op == OP_SET_BP) begin
                    bp_en_d[i]   = 1'b1;
                    bp_addr_d[i] = cmd_addr;
                end else if (cmd_op == OP_CLR_BP) begin
                    bp_en_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q      <= ST_HALT;
            skip_q       <= 1'b0;
            stop_cause_q <= 2'd0;
            bp_hit_idx_q <= 2'd0;
            instr_cnt_q  <= 32'd0;
            bp_en_q      <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            stop_cause_q <= stop_cause_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            instr_cnt_q  <= instr_cnt_d;
            bp_en_q      <= bp_en_d;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= bp_addr_d[i];
            end
        end
    end

    assign stop_cause = stop_cause_q;
    assign bp_hit_idx = bp_hit_idx_q;
    assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_sdu_exec_ctrl.sv
// Bench for sdu_exec_ctrl: directed vector table, randomized run against a rule-level model, and mid-run reset.
module tb_sdu_exec_ctrl;
    localparam int AW  = 32;
    localparam int NBP = 2;

    localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, STEP = 3'd2, HALT = 3'd3, SETBP = 3'd4, CLRBP = 3'd5;

    logic          cpu_clk = 1'b0;
    logic          cpu_rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [1:0]    cmd_idx = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] pc = '0;
    logic          cpu_en;
    logic          halted;
    logic [1:0]    stop_cause;
    logic [1:0]    bp_hit_idx;
    logic [31:0]   instr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sdu_exec_ctrl #(.ADDR_WIDTH(AW), .NUM_BP(NBP)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_addr(cmd_addr), .pc(pc),
        .cpu_en(cpu_en), .halted(halted), .stop_cause(stop_cause),
        .bp_hit_idx(bp_hit_idx), .instr_cnt(instr_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Reference model: mode 0 = halted, 1 = running freely, 2 = executing one step.
    int          m_mode;
    bit          m_skip;
    bit          m_bpen [4];
    logic [31:0] m_bpa  [4];
    int          m_cause, m_hit;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        m_mode = 0; m_skip = 0; m_cause = 0; m_hit = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_bpen[i] = 0;
            m_bpa[i]  = 0;
        end
    endfunction

    function automatic int model_match(input logic [31:0] p);
        for (int i = 0; i < NBP; i++)
            if (m_bpen[i] && m_bpa[i] == p) return i;
        return -1;
    endfunction

    function automatic bit model_en(input logic [31:0] p);
        if (m_mode == 2) return 1;
        if (m_mode == 1) return (model_match(p) < 0) || m_skip;
        return 0;
    endfunction

    function automatic void model_step(input bit v, input logic [2:0] op, input logic [1:0] idx,
                                       input logic [31:0] addr, input logic [31:0] p);
        bit en  = model_en(p);
        int mt  = model_match(p);
        bit s   = m_skip;
        bit acc = v && (m_mode != 2);
        if (en) begin
            m_cnt  = m_cnt + 1;
            m_skip = 0;
        end
        if (m_mode == 0) begin
            if (acc && op == RUN) begin m_mode = 1; m_skip = 1; end
            else if (acc && op == STEP) m_mode = 2;
        end else if (m_mode == 1) begin
            if (mt >= 0 && !s) begin m_mode = 0; m_cause = 3; m_hit = mt; end
            else if (acc && op == HALT) begin m_mode = 0; m_cause = 1; end
        end else begin
            m_mode = 0; m_cause = 2;
        end
        if (acc && op == SETBP && int'(idx) < NBP) begin m_bpen[idx] = 1; m_bpa[idx] = addr; end
        if (acc && op == CLRBP && int'(idx) < NBP) m_bpen[idx] = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [1:0] idx,
                         input logic [31:0] addr, input logic [31:0] p);
        cmd_valid = v; cmd_op = op; cmd_idx = idx; cmd_addr = addr; pc = p;
    endtask

    task automatic check_model();
        chk("cpu_en",     32'(cpu_en),     32'(model_en(pc)));
        chk("cmd_ready",  32'(cmd_ready),  32'(m_mode != 2));
        chk("halted",     32'(halted),     32'(m_mode == 0));
        chk("stop_cause", 32'(stop_cause), 32'(m_cause));
        chk("bp_hit_idx", 32'(bp_hit_idx), 32'(m_hit));
        chk("instr_cnt",  instr_cnt,       m_cnt);
    endtask

    // One cycle: drive after the falling edge, sample 1 ns later, advance the model, cross the rising edge.
    task automatic cyc_m(input bit v, input logic [2:0] op, input logic [1:0] idx,
                         input logic [31:0] addr, input logic [31:0] p);
        drive(v, op, idx, addr, p);
        #1;
        check_model();
        model_step(v, op, idx, addr, p);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    typedef struct {
        bit          v;
        logic [2:0]  op;
        logic [1:0]  idx;
        logic [31:0] addr;
        logic [31:0] pc;
        bit          e_en, e_h, e_rdy;
        logic [1:0]  e_c, e_i;
        logic [31:0] e_n;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit v, input logic [2:0] op, input logic [1:0] idx,
                                input logic [31:0] addr, input logic [31:0] p,
                                input bit en, input bit h, input bit rdy,
                                input logic [1:0] c, input logic [1:0] i, input logic [31:0] n);
        vec_t t;
        t.v = v; t.op = op; t.idx = idx; t.addr = addr; t.pc = p;
        t.e_en = en; t.e_h = h; t.e_rdy = rdy; t.e_c = c; t.e_i = i; t.e_n = n;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [31:0] p;
        bit          en_m;

        // Reset then idle; STEP; breakpoint at 0x10; resume over it; CLR_BP + HALT.
        for (int k = 0; k < 5; k++) add(0, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, STEP,  0, 0,     0,     0, 1, 1, 0, 0, 0);
        add(0, NOP,   0, 0,     0,     1, 0, 0, 0, 0, 0);
        add(0, NOP,   0, 0,     4,     0, 1, 1, 2, 0, 1);
        add(1, SETBP, 0, 'h10,  0,     0, 1, 1, 2, 0, 1);
        add(1, RUN,   0, 0,     0,     0, 1, 1, 2, 0, 1);
        for (int k = 0; k < 4; k++) add(0, NOP, 0, 0, 32'(4 * k), 1, 0, 1, 2, 0, 32'(1 + k));
        add(0, NOP,   0, 0,     'h10,  0, 0, 1, 2, 0, 5);
        add(0, NOP,   0, 0,     'h10,  0, 1, 1, 3, 0, 5);
        add(1, RUN,   0, 0,     'h10,  0, 1, 1, 3, 0, 5);
        add(0, NOP,   0, 0,     'h10,  1, 0, 1, 3, 0, 5);
        add(1, CLRBP, 0, 0,     'h14,  1, 0, 1, 3, 0, 6);
        add(0, NOP,   0, 0,     'h18,  1, 0, 1, 3, 0, 7);
        add(0, NOP,   0, 0,     'h10,  1, 0, 1, 3, 0, 8);
        add(1, HALT,  0, 0,     'h14,  1, 0, 1, 3, 0, 9);
        add(0, NOP,   0, 0,     'h18,  0, 1, 1, 1, 0, 10);
        // Two breakpoints on 0x20, an out-of-range index, and HALT coinciding with the hit.
        add(1, SETBP, 0, 'h20,  0,     0, 1, 1, 1, 0, 10);
        add(1, SETBP, 1, 'h20,  0,     0, 1, 1, 1, 0, 10);
        add(1, SETBP, 3, 'h1C,  0,     0, 1, 1, 1, 0, 10);
        add(1, RUN,   0, 0,     'h18,  0, 1, 1, 1, 0, 10);
        add(0, NOP,   0, 0,     'h18,  1, 0, 1, 1, 0, 10);
        add(0, NOP,   0, 0,     'h1C,  1, 0, 1, 1, 0, 11);
        add(1, HALT,  0, 0,     'h20,  0, 0, 1, 1, 0, 12);
        add(0, NOP,   0, 0,     'h20,  0, 1, 1, 3, 0, 12);
        // Only bp1 left: hit index must report 1; HALT while halted changes nothing.
        add(1, CLRBP, 0, 0,     0,     0, 1, 1, 3, 0, 12);
        add(1, RUN,   0, 0,     'h18,  0, 1, 1, 3, 0, 12);
        add(0, NOP,   0, 0,     'h18,  1, 0, 1, 3, 0, 12);
        add(0, NOP,   0, 0,     'h1C,  1, 0, 1, 3, 0, 13);
        add(0, NOP,   0, 0,     'h20,  0, 0, 1, 3, 0, 14);
        add(0, NOP,   0, 0,     'h20,  0, 1, 1, 3, 1, 14);
        add(1, HALT,  0, 0,     0,     0, 1, 1, 3, 1, 14);
        add(0, NOP,   0, 0,     0,     0, 1, 1, 3, 1, 14);

        model_reset();
        repeat (3) @(negedge cpu_clk);
        cpu_rstn = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].op, vecs[k].idx, vecs[k].addr, vecs[k].pc);
            #1;
            chk($sformatf("vec%0d cpu_en", k),     32'(cpu_en),     32'(vecs[k].e_en));
            chk($sformatf("vec%0d halted", k),     32'(halted),     32'(vecs[k].e_h));
            chk($sformatf("vec%0d cmd_ready", k),  32'(cmd_ready),  32'(vecs[k].e_rdy));
            chk($sformatf("vec%0d stop_cause", k), 32'(stop_cause), 32'(vecs[k].e_c));
            chk($sformatf("vec%0d bp_hit_idx", k), 32'(bp_hit_idx), 32'(vecs[k].e_i));
            chk($sformatf("vec%0d instr_cnt", k),  instr_cnt,       vecs[k].e_n);
            model_step(vecs[k].v, vecs[k].op, vecs[k].idx, vecs[k].addr, vecs[k].pc);
            @(posedge cpu_clk);
            @(negedge cpu_clk);
        end

        // Randomized commands with a PC that advances when the CPU is enabled.
        p = 0;
        for (int k = 0; k < 800; k++) begin
            bit          v   = ($urandom_range(0, 2) == 0);
            logic [2:0]  op  = 3'($urandom_range(0, 7));
            logic [1:0]  idx = 2'($urandom_range(0, 3));
            logic [31:0] a   = 32'($urandom_range(0, 15)) << 2;
            en_m = model_en(p);
            cyc_m(v, op, idx, a, p);
            if ($urandom_range(0, 9) == 0) p = 32'($urandom_range(0, 15)) << 2;
            else if (en_m) p = (p + 4) & 32'h3F;
        end

        // Reset in the middle of RUN with seven instructions retired.
        cpu_rstn = 1'b0;
        model_reset();
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        cyc_m(1, SETBP, 0, 'h10, 0);
        cyc_m(1, RUN,   0, 0, 'h100);
        for (int k = 0; k < 7; k++) cyc_m(0, NOP, 0, 0, 32'('h100 + 4 * k));
        drive(0, NOP, 0, 0, 'h11C);
        #1;
        chk("pre-reset instr_cnt", instr_cnt, 32'd7);
        chk("pre-reset cpu_en", 32'(cpu_en), 32'd1);
        cpu_rstn = 1'b0;
        #1;
        chk("async reset cpu_en", 32'(cpu_en), 32'd0);
        chk("async reset instr_cnt", instr_cnt, 32'd0);
        chk("async reset halted", 32'(halted), 32'd1);
        chk("async reset cmd_ready", 32'(cmd_ready), 32'd1);
        model_reset();
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        cyc_m(1, RUN, 0, 0, 'h8);
        for (int k = 0; k < 4; k++) begin
            drive(0, NOP, 0, 0, 32'('h8 + 4 * k));
            #1;
            chk($sformatf("post-reset run pc=%0h cpu_en", 'h8 + 4 * k), 32'(cpu_en), 32'd1);
            cyc_m(0, NOP, 0, 0, 32'('h8 + 4 * k));
        end
        cyc_m(0, NOP, 0, 0, 'h18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
